// File: rtl/ws_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ws_frame_ctrl
// Description : WS2812-family frame controller. Streams one pixel per LED
//               from a valid/ready source, feeds the NZR bit generator via
//               qmode (0 / 1 / RESET), then holds the latch (reset) time.
//               Supports a runtime LED count, auto-repeat and underrun abort.
// Revision    : 1.0 - initial release
// ============================================================================
module ws_frame_ctrl #(
    parameter int BITS_PER_LED = 24,
    parameter int MAX_LEDS     = 16,
    parameter int LED_W        = 8,
    parameter int RESET_CLKS   = 28100,
    parameter int RST_W        = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    auto_repeat,
    input  logic [LED_W-1:0]        num_leds,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic                    bdone,
    output logic                    start_coding,
    output logic [1:0]              qmode,
    output logic [LED_W-1:0]        led_index,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    all_done,
    output logic                    underrun
);

    localparam int BC_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam logic [1:0]        Q_RESET    = 2'b10;
    localparam logic [BC_W-1:0]   LAST_BIT   = BC_W'(BITS_PER_LED - 1);
    localparam logic [LED_W-1:0]  MAX_N      = LED_W'(MAX_LEDS);
    localparam logic [LED_W-1:0]  ONE_LED    = LED_W'(1);
    localparam logic [RST_W-1:0]  LATCH_LAST = RST_W'(RESET_CLKS - 1);

    logic [1:0]              state;
    logic [RST_W-1:0]        latch_cnt;
    logic [BC_W-1:0]         bit_cnt;
    logic [LED_W-1:0]        led_cnt;     // LEDs fully shifted out
    logic [LED_W-1:0]        fetched;     // pixels accepted this frame
    logic [LED_W-1:0]        n_leds;      // clamped LED count for this frame
    logic [BITS_PER_LED-1:0] shreg;
    logic [BITS_PER_LED-1:0] pbuf;        // one-entry prefetch buffer
    logic                    pbuf_full;

    logic                    hs;
    logic                    launch;
    logic                    last_led;
    logic [LED_W-1:0]        n_next;

    // Handshake, frame-launch and clamping helpers
    assign hs       = pix_valid && pix_ready;
    assign launch   = (start || auto_repeat) && (num_leds != '0);
    assign last_led = (led_cnt == (n_leds - ONE_LED));
    assign n_next   = (num_leds > MAX_N) ? MAX_N : num_leds;

    // Outputs decoded straight from state so they never depend on inputs
    always_comb begin
        pix_ready = 1'b0;
        qmode     = Q_RESET;
        if (state == S_LOAD) begin
            pix_ready = 1'b1;
        end else if (state == S_SHIFT) begin
            pix_ready = !pbuf_full && (fetched < n_leds);
            qmode     = {1'b0, shreg[BITS_PER_LED-1]};
        end
    end

    assign busy      = (state != S_IDLE);
    assign led_index = led_cnt;
    assign all_done  = (state == S_LATCH) && (latch_cnt == LATCH_LAST);

    // Frame sequencer: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_LATCH;
            latch_cnt    <= '0;
            bit_cnt      <= '0;
            led_cnt      <= '0;
            fetched      <= '0;
            n_leds       <= '0;
            shreg        <= '0;
            pbuf         <= '0;
            pbuf_full    <= 1'b0;
            start_coding <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            start_coding <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        n_leds    <= n_next;
                        bit_cnt   <= '0;
                        led_cnt   <= '0;
                        fetched   <= '0;
                        pbuf_full <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pix_valid) begin
                        shreg        <= pix_data;
                        fetched      <= ONE_LED;
                        start_coding <= 1'b1;
                        state        <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bdone && (bit_cnt == LAST_BIT)) begin
                        // End of a pixel: finish, reload, or abort on underrun
                        bit_cnt <= '0;
                        led_cnt <= led_cnt + ONE_LED;
                        if (last_led) begin
                            latch_cnt  <= '0;
                            frame_done <= 1'b1;
                            state      <= S_LATCH;
                        end else if (pbuf_full) begin
                            shreg     <= pbuf;
                            pbuf_full <= 1'b0;
                        end else if (hs) begin
                            shreg   <= pix_data;
                            fetched <= fetched + ONE_LED;
                        end else begin
                            latch_cnt <= '0;
                            underrun  <= 1'b1;
                            state     <= S_LATCH;
                        end
                    end else begin
                        if (bdone) begin
                            shreg   <= {shreg[BITS_PER_LED-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (hs) begin
                            pbuf      <= pix_data;
                            pbuf_full <= 1'b1;
                            fetched   <= fetched + ONE_LED;
                        end
                    end
                end
                S_LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LATCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ws_frame_ctrl
// Description : Self-checking bench for ws_frame_ctrl: table of frame
//               scenarios plus directed reset / auto-repeat / start sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws_frame_ctrl;

    localparam int BITS   = 24;
    localparam int MAXL   = 16;
    localparam int LW     = 8;
    localparam int RCLK   = 50;
    localparam int BD_PER = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            auto_repeat = 1'b0;
    logic [LW-1:0]   num_leds = '0;
    logic [BITS-1:0] pix_data = '0;
    logic            pix_valid = 1'b0;
    logic            bdone = 1'b0;
    logic            pix_ready, start_coding, busy, frame_done, all_done, underrun;
    logic [1:0]      qmode;
    logic [LW-1:0]   led_index;

    ws_frame_ctrl #(
        .BITS_PER_LED (BITS),
        .MAX_LEDS     (MAXL),
        .LED_W        (LW),
        .RESET_CLKS   (RCLK),
        .RST_W        (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .auto_repeat  (auto_repeat),
        .num_leds     (num_leds),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .bdone        (bdone),
        .start_coding (start_coding),
        .qmode        (qmode),
        .led_index    (led_index),
        .busy         (busy),
        .frame_done   (frame_done),
        .all_done     (all_done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int num;       // num_leds requested
        int npix;      // pixels offered by the source
        int gate;      // pixels >=1 held back until this bit count (-1 = never)
        int exp_bits;
        int exp_fd;
        int exp_ur;
        int exp_left;  // pixels left unconsumed in the source
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic            s_pix_ready, s_start_coding, s_busy, s_frame_done, s_all_done, s_underrun;
    logic [1:0]      s_qmode;
    logic [LW-1:0]   s_led_index;

    logic [BITS-1:0] q[$];
    bit              cap[$];
    int popped, gate, phase, fbits;
    bit released, in_latch;
    int n_fd, n_ur, n_ad, lat_cnt, last_lat, lat_bad, idx_bad, n_busy;

    function automatic logic [BITS-1:0] pix_of(int i);
        case (i)
            0:       return 24'hA50000;
            1:       return 24'h00FF01;
            default: return {8'(i * 37), 8'(255 - i), 8'(i * 5 + 3)};
        endcase
    endfunction

    // Number of captured bits that differ from the expected MSB-first stream
    function automatic int stream_errs();
        int errs = 0;
        logic [BITS-1:0] p;
        for (int k = 0; k < cap.size(); k++) begin
            p = pix_of(k / BITS);
            if (cap[k] != p[BITS-1-(k%BITS)]) errs++;
        end
        return errs;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: sample at negedge, then drive source/bdone after posedge
    task automatic cycle();
        logic hs;
        logic nb;
        @(negedge clk);
        s_pix_ready = pix_ready;   s_start_coding = start_coding;
        s_busy = busy;             s_frame_done = frame_done;
        s_all_done = all_done;     s_underrun = underrun;
        s_qmode = qmode;           s_led_index = led_index;
        if (s_start_coding === 1'b1) phase = 0;
        if (bdone && s_qmode[1] === 1'b0) begin
            if (s_led_index !== LW'(fbits / BITS)) idx_bad++;
            cap.push_back(s_qmode[0]);
            fbits++;
        end
        if (s_frame_done === 1'b1) n_fd++;
        if (s_underrun === 1'b1) n_ur++;
        if (s_frame_done === 1'b1 || s_underrun === 1'b1) begin
            in_latch = 1; lat_cnt = 0; fbits = 0;
        end
        if (in_latch) lat_cnt++;
        if (s_all_done === 1'b1) begin
            n_ad++;
            last_lat = lat_cnt;
            if (!in_latch || lat_cnt != RCLK) lat_bad++;
            in_latch = 0; lat_cnt = 0;
        end
        if (s_busy === 1'b1) n_busy++;
        hs = pix_valid && (s_pix_ready === 1'b1);
        @(posedge clk);
        #1;
        if (hs) begin
            void'(q.pop_front());
            popped++;
        end
        phase++;
        nb = 1'b0;
        if (phase >= BD_PER) begin nb = 1'b1; phase = 0; end
        bdone = nb;
        if (gate >= 0 && nb && cap.size() == gate) released = 1;
        pix_valid = (q.size() > 0) && (popped == 0 || gate < 0 || released);
        pix_data  = (q.size() > 0) ? q[0] : '0;
    endtask

    task automatic clear_stats();
        cap.delete(); q.delete();
        n_fd = 0; n_ur = 0; n_ad = 0; lat_bad = 0; idx_bad = 0; n_busy = 0;
        popped = 0; released = 0; fbits = 0; gate = -1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && s_busy !== 1'b0; i++) cycle();
        check("reach_idle", int'(s_busy), 0);
    endtask

    task automatic run_until_ad(input int target, input int bound);
        for (int i = 0; i < bound && n_ad < target; i++) cycle();
        check("all_done_count", n_ad, target);
    endtask

    task automatic start_frame(input int num, input int npix);
        for (int i = 0; i < npix; i++) q.push_back(pix_of(i));
        num_leds = LW'(num);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{num: 2,  npix: 2,  gate: -1, exp_bits: 48,  exp_fd: 1, exp_ur: 0, exp_left: 0};
        vecs[1] = '{num: 20, npix: 20, gate: -1, exp_bits: 384, exp_fd: 1, exp_ur: 0, exp_left: 4};
        vecs[2] = '{num: 2,  npix: 2,  gate: 24, exp_bits: 24,  exp_fd: 0, exp_ur: 1, exp_left: 1};
        vecs[3] = '{num: 2,  npix: 2,  gate: 23, exp_bits: 48,  exp_fd: 1, exp_ur: 0, exp_left: 0};
        vecs[4] = '{num: 1,  npix: 1,  gate: -1, exp_bits: 24,  exp_fd: 1, exp_ur: 0, exp_left: 0};
        vecs[5] = '{num: 3,  npix: 3,  gate: -1, exp_bits: 72,  exp_fd: 1, exp_ur: 0, exp_left: 0};

        phase = 0; in_latch = 0; lat_cnt = 0; last_lat = 0;
        clear_stats();

        // Power-on reset followed by the full latch period
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        in_latch = 1; lat_cnt = 0;
        cycle();
        check("rst_qmode", int'(s_qmode), 2);
        check("rst_busy", int'(s_busy), 1);
        check("rst_pix_ready", int'(s_pix_ready), 0);
        check("rst_start_coding", int'(s_start_coding), 0);
        check("rst_frame_done", int'(s_frame_done), 0);
        check("rst_underrun", int'(s_underrun), 0);
        check("rst_all_done", int'(s_all_done), 0);
        check("rst_led_index", int'(s_led_index), 0);
        run_until_ad(1, 100);
        check("rst_latch_len", last_lat, RCLK);
        cycle();
        check("rst_then_idle", int'(s_busy), 0);

        // Table of frame scenarios
        for (int v = 0; v < 6; v++) begin
            wait_idle();
            clear_stats();
            gate = vecs[v].gate;
            start_frame(vecs[v].num, vecs[v].npix);
            run_until_ad(1, 10000);
            check($sformatf("v%0d_bits", v), cap.size(), vecs[v].exp_bits);
            check($sformatf("v%0d_stream", v), stream_errs(), 0);
            check($sformatf("v%0d_frame_done", v), n_fd, vecs[v].exp_fd);
            check($sformatf("v%0d_underrun", v), n_ur, vecs[v].exp_ur);
            check($sformatf("v%0d_latch", v), lat_bad, 0);
            check($sformatf("v%0d_left", v), q.size(), vecs[v].exp_left);
            check($sformatf("v%0d_led_index", v), idx_bad, 0);
        end

        // start with num_leds == 0 is ignored
        wait_idle();
        clear_stats();
        start_frame(0, 0);
        repeat (10) cycle();
        check("zero_leds_busy", n_busy, 0);

        // start during a frame is not queued
        wait_idle();
        clear_stats();
        start_frame(1, 2);
        for (int i = 0; i < 2000 && cap.size() < 10; i++) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_until_ad(1, 2000);
        n_busy = 0;
        repeat (20) cycle();
        check("midstart_bits", cap.size(), 24);
        check("midstart_fd", n_fd, 1);
        check("midstart_left", q.size(), 1);
        check("midstart_busy", n_busy, 0);

        // auto_repeat: back-to-back single-LED frames
        wait_idle();
        clear_stats();
        for (int i = 0; i < 3; i++) q.push_back(pix_of(i));
        num_leds = LW'(1);
        auto_repeat = 1'b1;
        for (int i = 0; i < 5000 && n_fd < 3; i++) cycle();
        auto_repeat = 1'b0;
        run_until_ad(3, 200);
        n_busy = 0;
        repeat (10) cycle();
        check("auto_bits", cap.size(), 72);
        check("auto_stream", stream_errs(), 0);
        check("auto_fd", n_fd, 3);
        check("auto_ur", n_ur, 0);
        check("auto_latch", lat_bad, 0);
        check("auto_led_index", idx_bad, 0);
        check("auto_left", q.size(), 0);
        check("auto_idle_busy", n_busy, 0);

        // reset in the middle of LED 1, bit 10
        wait_idle();
        clear_stats();
        start_frame(2, 2);
        for (int i = 0; i < 2000 && cap.size() < 34; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_latch = 1; lat_cnt = 0; fbits = 0;
        cycle();
        check("midrst_qmode", int'(s_qmode), 2);
        check("midrst_led_index", int'(s_led_index), 0);
        check("midrst_pix_ready", int'(s_pix_ready), 0);
        check("midrst_busy", int'(s_busy), 1);
        run_until_ad(1, 100);
        check("midrst_latch_len", last_lat, RCLK);
        check("midrst_fd", n_fd, 0);
        check("midrst_bits", cap.size(), 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
